// File: rtl/blink_sequencer_pkg.sv
// Shared definitions for the LED blink sequencer: FSM state encoding,
// default divider width and the half-period helper.
// Ports: none (package).
package blink_sequencer_pkg;

  localparam int unsigned DIV_W_DEFAULT = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Half-period for a rate select: base divided by 2**sel, never below one cycle.
  function automatic int unsigned half_period(input int unsigned tick_div,
                                              input logic [1:0]  sel);
    int unsigned p;
    p = tick_div >> sel;
    if (p == 0) p = 1;
    return p;
  endfunction

endpackage

// File: rtl/blink_sequencer_tick_divider.sv
// Programmable tick divider: counts 0..period-1, tick is high while the count
// sits at period-1, then wraps to 0. clr zeroes the count on the next edge.
// Ports: clk, rst (async, active-high), clr, period[DIV_W-1:0] -> tick.
module tick_divider
  import blink_sequencer_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  assign tick = (count_q == period - DIV_W'(1));

  always_comb begin
    count_d = count_q + DIV_W'(1);
    if (clr || tick) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/blink_sequencer.sv
// Blink sequencer: on an accepted start emits N blinks of P cycles on / P off,
// then pulses done for one cycle. Optional feature macro: SEQ_ABORT_EN (adds abort).
// Ports: clk, rst (async, active-high), start, blink_count[CNT_W-1:0],
//        period_sel[1:0], [abort] -> busy, done, led (all registered).
module blink_sequencer
  import blink_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned DIV_W    = DIV_W_DEFAULT,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] blink_count,
  input  logic [1:0]       period_sel,
`ifdef SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             led
);

  state_e           state_q;
  logic [CNT_W-1:0] remain_q;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] period_d;
  logic             led_q;
  logic             busy_q;
  logic             done_q;
  logic             tick;
  logic             div_clr;

  assign period_d = DIV_W'(half_period(TICK_DIV, period_sel));

  // The divider only runs while a blink phase is active, so it always starts
  // a burst from zero and wraps on its own between ON and OFF.
`ifdef SEQ_ABORT_EN
  assign div_clr = (state_q == ST_IDLE) || (state_q == ST_FIN) || abort;
`else
  assign div_clr = (state_q == ST_IDLE) || (state_q == ST_FIN);
`endif

  tick_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (div_clr),
    .period (period_q),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      period_q <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
`ifdef SEQ_ABORT_EN
      // abort wins over start in IDLE and over a tick in ON/OFF; done is never issued.
      if (abort) begin
        state_q <= ST_IDLE;
        led_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else
`endif
      begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              remain_q <= blink_count;
              period_q <= period_d;
              if (blink_count != '0) begin
                state_q <= ST_ON;
                led_q   <= 1'b1;
                busy_q  <= 1'b1;
              end else begin
                state_q <= ST_FIN;
                done_q  <= 1'b1;
              end
            end
          end
          ST_ON: begin
            if (tick) begin
              state_q <= ST_OFF;
              led_q   <= 1'b0;
            end
          end
          ST_OFF: begin
            if (tick) begin
              remain_q <= remain_q - CNT_W'(1);
              if (remain_q == CNT_W'(1)) begin
                state_q <= ST_FIN;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_ON;
                led_q   <= 1'b1;
              end
            end
          end
          ST_FIN: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer with TICK_DIV=8 (P = 8,4,2,1 for sel 0..3).
// Inputs change on the falling edge; outputs are compared on the falling edge
// against a timeline model: after an accepted start at edge k, offset t<2NP is busy
// with led = even(t/P), t==2NP is the done cycle, anything later is idle.
module tb_blink_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] blink_count = '0;
  logic [1:0] period_sel = '0;
`ifdef SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       busy;
  logic       done;
  logic       led;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  blink_sequencer #(
    .TICK_DIV (8),
    .DIV_W    (26),
    .CNT_W    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .blink_count (blink_count),
    .period_sel  (period_sel),
`ifdef SEQ_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .led         (led)
  );

  // ---------------- reference timeline model ----------------
  int cyc = 0;
  bit m_has = 1'b0;
  int m_start = 0;
  int m_n = 0;
  int m_p = 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_has = 1'b0;
    end else begin
      cyc++;
`ifdef SEQ_ABORT_EN
      if (abort) m_has = 1'b0;
      else
`endif
      // The block is back in IDLE once the done cycle (offset 2NP) has passed.
      if (start && (!m_has || (cyc - m_start) >= 2 * m_n * m_p + 2)) begin
        m_has   = 1'b1;
        m_start = cyc;
        m_n     = int'(blink_count);
        m_p     = 8 >> period_sel;
        if (m_p == 0) m_p = 1;
      end
    end
  end

  function automatic logic [2:0] model_out();
    int t;
    int total;
    if (!m_has) return 3'b000;
    t = cyc - m_start;
    total = 2 * m_n * m_p;
    if (t < total) return {(((t / m_p) % 2) == 0), 1'b1, 1'b0};
    if (t == total) return 3'b001;
    return 3'b000;
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic cmp3(input string name, input logic [2:0] act, input logic [2:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: {led,busy,done} got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input string name);
    @(posedge clk);
    @(negedge clk);
    cmp3(name, {led, busy, done}, model_out());
  endtask

  // Start one burst from IDLE and measure it until done (bounded).
  task automatic run_burst(input logic [3:0] n, input logic [1:0] sel,
                           output int busy_cnt, output int hi_cnt,
                           output int rises, output int done_idx);
    logic prev_led;
    int   idx;
    bit   seen;
    prev_led = 1'b0;
    idx      = 0;
    seen     = 1'b0;
    busy_cnt = 0;
    hi_cnt   = 0;
    rises    = 0;
    done_idx = -1;
    start       = 1'b1;
    blink_count = n;
    period_sel  = sel;
    cycle("burst");
    start = 1'b0;
    // Config inputs are free to move once latched.
    blink_count = 4'($urandom_range(15));
    period_sel  = 2'($urandom_range(3));
    while (!seen && idx < 400) begin
      if (busy) busy_cnt++;
      if (led) hi_cnt++;
      if (led && !prev_led) rises++;
      prev_led = led;
      if (done) begin
        seen     = 1'b1;
        done_idx = idx;
      end else begin
        cycle("burst");
        idx++;
      end
    end
    cycle("burst_to_idle");
  endtask

  typedef struct {
    logic [3:0] n;
    logic [1:0] sel;
    int         busy_cycles;
    int         led_high;
    int         blinks;
    int         done_idx;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int b, h, r, d;

    vecs[0] = '{4'd3,  2'd1, 24, 12, 3,  24};
    vecs[1] = '{4'd0,  2'd0, 0,  0,  0,  0};
    vecs[2] = '{4'd1,  2'd3, 2,  1,  1,  2};
    vecs[3] = '{4'd2,  2'd0, 32, 16, 2,  32};
    vecs[4] = '{4'd15, 2'd3, 30, 15, 15, 30};
    vecs[5] = '{4'd1,  2'd2, 4,  2,  1,  4};
    vecs[6] = '{4'd4,  2'd2, 16, 8,  4,  16};

    // Reset applies without any clock edge, then holds everything low.
    #1 cmp3("reset_async_t0", {led, busy, done}, 3'b000);
    for (int i = 0; i < 10; i++) cycle("reset_hold");
    rst = 1'b0;
    cycle("after_reset");

    // Table-driven bursts.
    for (int i = 0; i < 7; i++) begin
      run_burst(vecs[i].n, vecs[i].sel, b, h, r, d);
      cmp($sformatf("vec%0d_busy_cycles", i), b, vecs[i].busy_cycles);
      cmp($sformatf("vec%0d_led_high", i), h, vecs[i].led_high);
      cmp($sformatf("vec%0d_blinks", i), r, vecs[i].blinks);
      cmp($sformatf("vec%0d_done_idx", i), d, vecs[i].done_idx);
    end

    // Extra start pulses during ON, OFF and FIN are all ignored (N=1, P=1).
    start = 1'b1; blink_count = 4'd1; period_sel = 2'd3;
    cycle("t4_on");
    cmp3("t4_on_const", {led, busy, done}, 3'b110);
    cycle("t4_off");
    cmp3("t4_off_const", {led, busy, done}, 3'b010);
    cycle("t4_fin");
    cmp3("t4_fin_const", {led, busy, done}, 3'b001);
    cycle("t4_fin_start_ignored");
    cmp3("t4_idle_const", {led, busy, done}, 3'b000);
    start = 1'b0;
    cycle("t4_idle2");
    cmp3("t4_idle2_const", {led, busy, done}, 3'b000);

    // Reset mid-burst: outputs drop without a clock edge, no done, restart works.
    start = 1'b1; blink_count = 4'd2; period_sel = 2'd0;
    cycle("t5_burst");
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle("t5_burst");
    #2 rst = 1'b1;
    #1 cmp3("t5_rst_async", {led, busy, done}, 3'b000);
    for (int i = 0; i < 3; i++) begin
      cycle("t5_rst_hold");
      cmp3("t5_rst_hold_const", {led, busy, done}, 3'b000);
    end
    rst = 1'b0;
    cycle("t5_release");
    cmp3("t5_release_no_done", {led, busy, done}, 3'b000);
    run_burst(4'd1, 2'd3, b, h, r, d);
    cmp("t5_restart_busy", b, 2);
    cmp("t5_restart_done_idx", d, 2);

`ifdef SEQ_ABORT_EN
    // Abort coincident with a tick (P=2, offset 7 ends an OFF phase).
    start = 1'b1; blink_count = 4'd5; period_sel = 2'd2;
    cycle("t6_burst");
    start = 1'b0;
    for (int i = 0; i < 7; i++) cycle("t6_burst");
    cmp3("t6_pre_abort", {led, busy, done}, 3'b010);
    abort = 1'b1;
    cycle("t6_abort");
    cmp3("t6_abort_const", {led, busy, done}, 3'b000);
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle("t6_after_abort");
      cmp3("t6_no_done", {led, busy, done}, 3'b000);
    end
    // Abort beats start in IDLE.
    start = 1'b1; abort = 1'b1; blink_count = 4'd3; period_sel = 2'd3;
    cycle("t6_abort_vs_start");
    cmp3("t6_abort_vs_start_const", {led, busy, done}, 3'b000);
    start = 1'b0; abort = 1'b0;
    cycle("t6_idle");
`endif

    // Randomized traffic against the timeline model.
    for (int c = 0; c < 2000; c++) begin
      start       = ($urandom_range(7) == 0);
      blink_count = 4'($urandom_range(15));
      period_sel  = 2'($urandom_range(3));
`ifdef SEQ_ABORT_EN
      abort = ($urandom_range(39) == 0);
`endif
      cycle("random");
    end
    start = 1'b0;
`ifdef SEQ_ABORT_EN
    abort = 1'b0;
`endif
    for (int c = 0; c < 260; c++) cycle("drain");
    cmp3("drain_idle", {led, busy, done}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
